// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the ARM core.
//   - pipe_state_e : occupancy state of a stage. The encoding equals the
//                    entry count, so OCCUPANCY is simply the state value.
//   - CTRL_*       : bit positions of the side-effecting control bits
//                    inside the CTRL_W control vector.
//   - PIPE_*_W     : default payload and control widths.
package pipe_pkg;

    localparam int PIPE_DATA_W = 192;
    localparam int PIPE_CTRL_W = 6;

    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEM2REG     = 1;
    localparam int CTRL_MEMWRITE    = 2;
    localparam int CTRL_BRANCH_ZERO = 3;
    localparam int CTRL_MEMREAD     = 4;
    localparam int CTRL_ZERO        = 5;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of a pipeline stage: a W-bit register with load enable
// and synchronous clear. Clear wins over load.
//   CLK  : rising-edge clock
//   CLR  : synchronous clear (active high)
//   LOAD : capture D at the next edge
//   D    : next value
//   Q    : stored value
module pipe_entry #(
    parameter int W = 198
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (CLR)
            Q <= '0;
        else if (LOAD)
            Q <= D;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled ready/valid pipeline register for one inter-stage boundary.
// Holds one entry (SKID=0, combinational IN_READY) or two entries (SKID=1,
// registered IN_READY, skid entry absorbs the one-cycle-late ready).
// Control bits are masked to zero whenever no valid entry is presented.
//   CLK, RESET          : clock, synchronous active-high reset
//   IN_VALID/IN_READY   : upstream handshake
//   IN_CTRL, IN_DATA    : upstream control bits and payload
//   FLUSH               : squash held and incoming entries
//   OUT_VALID/OUT_READY : downstream handshake
//   OUT_CTRL, OUT_DATA  : presented control (gated) and payload (held)
//   OCCUPANCY           : number of entries held (0..2)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);

    localparam int ENT_W = CTRL_W + DATA_W;

    pipe_state_e      state, state_nxt;
    logic             accept, drain;
    logic             main_load, skid_load, main_from_skid;
    logic [ENT_W-1:0] main_d, main_q, skid_q;
    logic [CTRL_W-1:0] main_ctrl;

    assign OUT_VALID = (state != PS_EMPTY);
    assign OCCUPANCY = state;
    assign accept    = IN_VALID & IN_READY;
    assign drain     = OUT_VALID & OUT_READY;

    // Next state and entry load enables. Loads are suppressed on FLUSH so a
    // squashed instruction never lands in the payload registers either.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            PS_EMPTY: begin
                if (accept) begin
                    state_nxt = PS_ONE;
                    main_load = 1'b1;
                end
            end
            PS_ONE: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept && SKID != 0) begin
                    state_nxt = PS_FULL;
                    skid_load = 1'b1;
                end else if (drain) begin
                    state_nxt = PS_EMPTY;
                end
            end
            PS_FULL: begin
                // Skid always drains after main: promote it into main.
                if (drain) begin
                    state_nxt      = PS_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = PS_EMPTY;
        endcase
        if (FLUSH) begin
            state_nxt = PS_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= PS_EMPTY;
        else
            state <= state_nxt;
    end

    assign main_d = main_from_skid ? skid_q : {IN_CTRL, IN_DATA};

    pipe_entry #(.W(ENT_W)) u_main (
        .CLK  (CLK),
        .CLR  (RESET),
        .LOAD (main_load),
        .D    (main_d),
        .Q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_r;

            // Registered ready: low only while both entries are occupied.
            always_ff @(posedge CLK) begin
                if (RESET)
                    in_ready_r <= 1'b1;
                else
                    in_ready_r <= (state_nxt != PS_FULL);
            end
            assign IN_READY = in_ready_r;

            pipe_entry #(.W(ENT_W)) u_skid (
                .CLK  (CLK),
                .CLR  (RESET),
                .LOAD (skid_load),
                .D    ({IN_CTRL, IN_DATA}),
                .Q    (skid_q)
            );
        end else begin : g_noskid
            assign IN_READY = !OUT_VALID | OUT_READY;
            assign skid_q   = '0;
        end
    endgenerate

    assign main_ctrl = main_q[DATA_W +: CTRL_W];
    assign OUT_CTRL  = main_ctrl & {CTRL_W{OUT_VALID}};
    assign OUT_DATA  = main_q[DATA_W-1:0];

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined ARM core. It replaces fixed free-running stage registers with a ready/valid stage that supports stall back-pressure, flush-to-bubble, and an optional skid entry for full throughput under registered ready. Control bits are forced to zero whenever the stage holds no valid instruction, so downstream stages never see spurious writes.

## Interface
- DATA_W, 192: payload width (branch target, ALU value, Rt read data, instruction word, destination register, ALU control, etc., concatenated by the instantiating stage)
- CTRL_W, 6: side-effecting control bits (REGWRITE, MEM2REG, MEMWRITE, BRANCH_ZERO, MEMREAD, ZERO); zeroed on bubble
- SKID, 1: 1 = two-entry stage with registered IN_READY; 0 = single entry with combinational IN_READY

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  upstream holds a valid instruction
- IN_READY  out  1  stage accepts this cycle
- IN_CTRL  in  CTRL_W  upstream control bits
- IN_DATA  in  DATA_W  upstream payload
- FLUSH  in  1  squash all held and incoming entries (branch taken / exception)
- OUT_VALID  out  1  stage presents a valid instruction
- OUT_READY  in  1  downstream accepts (0 = stall)
- OUT_CTRL  out  CTRL_W  control bits; all zero when OUT_VALID=0
- OUT_DATA  out  DATA_W  payload; holds last value when OUT_VALID=0
- OCCUPANCY  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Accept = IN_VALID & IN_READY; Drain = OUT_VALID & OUT_READY.
- SKID=1 states: EMPTY (occ 0), ONE (main entry valid), FULL (main + skid valid).
  - EMPTY: Accept -> ONE (load main).
  - ONE: Accept & Drain -> ONE (main <= input); Accept & !Drain -> FULL (skid <= input); Drain only -> EMPTY; neither -> ONE.
  - FULL: Drain -> ONE (main <= skid); no Accept possible (IN_READY=0).
  - IN_READY = (state != FULL), registered.
- SKID=0: states EMPTY/ONE only; IN_READY = !OUT_VALID | OUT_READY (combinational); Accept & Drain in ONE stays ONE with new data.
- Order preserved: skid entry always drains after main entry.
- FLUSH: next state EMPTY regardless of Accept/Drain; an entry accepted in the flush cycle is discarded; IN_READY=1 next cycle.
- Priority: RESET > FLUSH > normal flow.
- OUT_CTRL = main_ctrl & {CTRL_W{OUT_VALID}}; payload registers are not cleared on flush (power), only on RESET.

## Timing
- Latency 1 cycle: data accepted at edge N is on OUT_* after edge N.
- Throughput 1 entry/cycle with OUT_READY held high, both SKID modes.
- SKID=1: no combinational path IN_* <-> OUT_*; OUT_READY to IN_READY is registered (one-cycle-late ready absorbed by skid).
- Reset (synchronous, edge where RESET=1): OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0, IN_READY=1, skid cleared.
- Reset or FLUSH mid-stall: both entries dropped at that edge; OUT_VALID=0 after it.
- Simultaneous FLUSH and IN_VALID: input not retained, IN_READY value in that cycle still reported per state.

## Structure
- Shared package pipe_pkg: state encoding (PS_EMPTY, PS_ONE, PS_FULL), control-bit index constants (CTRL_REGWRITE=0, CTRL_MEM2REG=1, CTRL_MEMWRITE=2, CTRL_BRANCH_ZERO=3, CTRL_MEMREAD=4, CTRL_ZERO=5), default widths.
- One sub-module pipe_entry: CTRL_W+DATA_W register with load enable and synchronous clear; instantiated as main and (SKID=1) skid entry. FSM and muxing in pipe_stage_reg.

## Test plan
- Reset: RESET=1 one cycle with IN_VALID=1 -> after edge OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0, IN_READY=1.
- Streaming: IN_VALID=1, OUT_READY=1, IN_DATA=1,2,3,4 on consecutive cycles -> OUT_DATA 1,2,3,4 one cycle later, no gaps, OCCUPANCY=1 throughout.
- Stall (SKID=1): send 0xA, 0xB with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=0xA held; raise OUT_READY -> 0xA then 0xB, IN_READY=1 cycle after first drain.
- Flush: FULL state holding ctrl=6'b000101, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0, flushed input never appears.
- Bubble gating: IN_VALID=0 with IN_CTRL=6'b111111 -> OUT_CTRL stays 0; OUT_DATA unchanged.
- SKID=0: OUT_READY=0 with entry held -> IN_READY=0 same cycle; OUT_READY=1 with IN_VALID=1 -> accept and drain same cycle, OCCUPANCY stays 1.
